// File: rtl/uart_rx_wb.sv
// Wishbone slave 8N1 UART receiver with a small receive FIFO, sticky error flags
// and a level interrupt that stays high while received data is pending.
module uart_rx_wb #(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack,
  input  logic        rx,
  output logic        irq
);

  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int NW   = PW + 1;

  // Bus handshake: a request is cyc & stb while ack is low; ack answers it on
  // the next edge for exactly one cycle, and all side effects land on that edge.

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]   count_q, count_d;
  logic            ovr_q, ovr_d, ferr_q, ferr_d;
  logic            ack_q, ack_d, irq_q, irq_d;
  logic [31:0]     dat_o_q, dat_o_d;

  logic            rx_s, push_req, frame_err;
  logic            req, rd_req, wr_req, empty, full, pop, push;
  logic            clr_ovr, clr_ferr;
  logic [3:0]      cnt4;
  logic [31:0]     status_w;
  logic            unused_bits;

  assign rx_s        = sync2_q;
  assign unused_bits = ^{adr[31:3], adr[1:0], dat_i[31:4], dat_i[1:0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CW'(CPB - 1)) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        // Leave at mid-stop so a start bit right behind the stop bit is caught.
        if (cnt_q == CW'(CPB - 1)) begin
          cnt_d     = '0;
          state_d   = IDLE;
          push_req  = rx_s;
          frame_err = !rx_s;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req      = cyc & stb & ~ack_q;
    rd_req   = req & ~we;
    wr_req   = req & we;
    empty    = (count_q == '0);
    full     = (count_q == NW'(FIFO_DEPTH));
    pop      = rd_req & ~adr[2] & ~empty;
    // A pop in the same cycle frees the slot, so a push at full still fits.
    push     = push_req & (~full | pop);
    clr_ovr  = wr_req & adr[2] & dat_i[2];
    clr_ferr = wr_req & adr[2] & dat_i[3];

    if (32'(count_q) > 32'd15) cnt4 = 4'hF;
    else                       cnt4 = 4'(count_q);
    status_w = {24'b0, cnt4, ferr_q, ovr_q, full, ~empty};

    ack_d   = req;
    dat_o_d = '0;
    if (rd_req) begin
      if (adr[2])     dat_o_d = status_w;
      else if (!empty) dat_o_d = {24'b0, mem_q[rd_ptr_q]};
    end

    ovr_d  = (push_req & full & ~pop) | (ovr_q & ~clr_ovr);
    ferr_d = frame_err | (ferr_q & ~clr_ferr);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + NW'(1);
    else if (pop && !push) count_d = count_q - NW'(1);

    irq_d = (count_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
      ack_q    <= 1'b0;
      dat_o_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      sync1_q  <= rx;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
      ack_q    <= ack_d;
      dat_o_q  <= dat_o_d;
      irq_q    <= irq_d;
    end
  end

  assign dat_o = dat_o_q;
  assign ack   = ack_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_uart_rx_wb.sv
// Bench for uart_rx_wb at 16 clocks per bit: serial frames in, Wishbone reads
// out, received bytes tracked in an expected queue.
module tb_uart_rx_wb;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;

  logic        clk, rst, cyc, stb, we, rx, ack, irq;
  logic [31:0] adr, dat_i, dat_o;

  int checks = 0;
  int errors = 0;
  int irq_rise_at = -1;
  logic [7:0] exp_q[$];

  uart_rx_wb #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cyc(cyc), .stb(stb), .we(we), .adr(adr),
    .dat_i(dat_i), .dat_o(dat_o), .ack(ack), .rx(rx), .irq(irq)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks: all start and end one time unit after a rising edge.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] bits;
    int k;
    bits = {stop, d, 1'b0};
    irq_rise_at = -1;
    k = 0;
    for (int b = 0; b < 10; b++) begin
      rx = bits[b];
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (irq === 1'b1 && irq_rise_at < 0) irq_rise_at = k;
        k++;
        @(posedge clk); #1;
      end
    end
    rx = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
    send_frame(d, 1'b1);
  endtask

  task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output logic ack_after);
    bit got;
    got = 0;
    rd = '0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = wd;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        rd = dat_o;
        got = 1;
      end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL wb_ack_timeout adr=%h: got no ack, required ack within 8 cycles", a);
    end
    @(negedge clk);
    ack_after = ack;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic aa;
    rst = 1'b1; rx = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b required 0", ack); end
    checks++; if (dat_o !== 32'h0) begin errors++; $display("FAIL rst_dat_o: got %h required 0", dat_o); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b required 0", irq); end
    @(posedge clk); #1;
    rst = 1'b0;
    rx = 1'b0;
    repeat (40) @(posedge clk); #1;
    checks++; if (2'(dut.state_q) !== 2'd2) begin errors++; $display("FAIL mid_frame_state: got %0d required 2", 2'(dut.state_q)); end
    rst = 1'b1; rx = 1'b1;
    @(negedge clk);
    checks++; if (2'(dut.state_q) !== 2'd0) begin errors++; $display("FAIL rst_abort_state: got %0d required 0", 2'(dut.state_q)); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (200) @(posedge clk); #1;
    wb_access(1'b0, 32'h4, 32'h0, rd, aa);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_status: got %h required 00000000", rd); end
    checks++; if (aa !== 1'b0) begin errors++; $display("FAIL ack_one_cycle: got %b required 0", aa); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b required 0", irq); end
    wb_access(1'b1, 32'h0, 32'hFF, rd, aa);
    wb_access(1'b0, 32'h0, 32'h0, rd, aa);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL empty_data_read: got %h required 00000000", rd); end
    checks++; if (aa !== 1'b0) begin errors++; $display("FAIL ack_one_cycle_data: got %b required 0", aa); end
  endtask

  task automatic test_single_byte();
    logic [31:0] rd;
    logic [7:0] e;
    logic aa;
    send_byte(8'hA5);
    checks++; if (irq_rise_at != 155) begin errors++; $display("FAIL irq_rise: got cycle %0d required 155", irq_rise_at); end
    wb_access(1'b0, 32'h4, 32'h0, rd, aa);
    checks++; if (rd !== 32'h11) begin errors++; $display("FAIL single_status: got %h required 00000011", rd); end
    wb_access(1'b0, 32'h0, 32'h0, rd, aa);
    e = exp_q.pop_front();
    checks++; if (rd !== {24'h0, e}) begin errors++; $display("FAIL single_data: got %h required %h", rd, {24'h0, e}); end
    wb_access(1'b0, 32'h4, 32'h0, rd, aa);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL single_status_after: got %h required 00000000", rd); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_irq_after: got %b required 0", irq); end
  endtask

  task automatic test_false_start();
    logic [31:0] rd;
    logic [7:0] e;
    logic aa;
    rx = 1'b0;
    repeat (4) @(posedge clk); #1;
    rx = 1'b1;
    repeat (30) @(posedge clk); #1;
    checks++; if (2'(dut.state_q) !== 2'd0) begin errors++; $display("FAIL false_start_state: got %0d required 0", 2'(dut.state_q)); end
    wb_access(1'b0, 32'h4, 32'h0, rd, aa);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL false_start_status: got %h required 00000000", rd); end
    send_byte(8'h3C);
    checks++; if (irq_rise_at != 155) begin errors++; $display("FAIL irq_rise_3c: got cycle %0d required 155", irq_rise_at); end
    wb_access(1'b0, 32'h0, 32'h0, rd, aa);
    e = exp_q.pop_front();
    checks++; if (rd !== {24'h0, e}) begin errors++; $display("FAIL after_false_start_data: got %h required %h", rd, {24'h0, e}); end
  endtask

  task automatic test_framing();
    logic [31:0] rd;
    logic aa;
    send_frame(8'h55, 1'b0);
    wb_access(1'b0, 32'h4, 32'h0, rd, aa);
    checks++; if (rd !== 32'h08) begin errors++; $display("FAIL ferr_status: got %h required 00000008", rd); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ferr_irq: got %b required 0", irq); end
    wb_access(1'b1, 32'h4, 32'h08, rd, aa);
    wb_access(1'b0, 32'h4, 32'h0, rd, aa);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ferr_clear: got %h required 00000000", rd); end
  endtask

  task automatic test_back_to_back();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h4;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (ack !== 1'(i % 2)) begin
        errors++;
        $display("FAIL b2b_ack[%0d]: got %b required %b", i, ack, 1'(i % 2));
      end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_overrun();
    logic [31:0] rd, ex;
    logic aa;
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    wb_access(1'b0, 32'h4, 32'h0, rd, aa);
    checks++; if (rd !== 32'h83) begin errors++; $display("FAIL full_status: got %h required 00000083", rd); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL full_irq: got %b required 1", irq); end
    send_byte(8'h09);
    wb_access(1'b0, 32'h4, 32'h0, rd, aa);
    checks++; if (rd !== 32'h87) begin errors++; $display("FAIL ovr_status: got %h required 00000087", rd); end
    for (int i = 0; i < 9; i++) begin
      wb_access(1'b0, 32'h0, 32'h0, rd, aa);
      ex = (exp_q.size() > 0) ? {24'h0, exp_q.pop_front()} : 32'h0;
      checks++; if (rd !== ex) begin errors++; $display("FAIL ovr_read[%0d]: got %h required %h", i, rd, ex); end
    end
    wb_access(1'b0, 32'h4, 32'h0, rd, aa);
    checks++; if (rd !== 32'h04) begin errors++; $display("FAIL ovr_sticky: got %h required 00000004", rd); end
    wb_access(1'b1, 32'h4, 32'h04, rd, aa);
    wb_access(1'b0, 32'h4, 32'h0, rd, aa);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ovr_clear: got %h required 00000000", rd); end
  endtask

  task automatic test_push_pop_full();
    logic [31:0] rd, rd_a, ex;
    logic aa, aa_a;
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i));
    wb_access(1'b0, 32'h4, 32'h0, rd, aa);
    checks++; if (rd !== 32'h83) begin errors++; $display("FAIL pp_full_status: got %h required 00000083", rd); end
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1;
        wb_access(1'b0, 32'h0, 32'h0, rd_a, aa_a);
      end
    join
    ex = {24'h0, exp_q.pop_front()};
    checks++; if (rd_a !== ex) begin errors++; $display("FAIL pp_aligned_read: got %h required %h", rd_a, ex); end
    exp_q.push_back(8'h77);
    wb_access(1'b0, 32'h4, 32'h0, rd, aa);
    checks++; if (rd !== 32'h83) begin errors++; $display("FAIL pp_status: got %h required 00000083", rd); end
    for (int i = 0; i < 8; i++) begin
      wb_access(1'b0, 32'h0, 32'h0, rd, aa);
      ex = (exp_q.size() > 0) ? {24'h0, exp_q.pop_front()} : 32'h0;
      checks++; if (rd !== ex) begin errors++; $display("FAIL pp_read[%0d]: got %h required %h", i, rd, ex); end
    end
    wb_access(1'b0, 32'h4, 32'h0, rd, aa);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL pp_final_status: got %h required 00000000", rd); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_false_start();
    test_framing();
    test_back_to_back();
    test_overrun();
    test_push_pop_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
